// File: rtl/dmux2way16_stream_pkg.sv
// Shared constants for the 2-way 16-bit stream demultiplexer.
// Default widths, channel indices and slot state encodings.
package dmux2way16_stream_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int CNT_W_DEFAULT = 16;

  localparam int CH0 = 0;
  localparam int CH1 = 1;

  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

endpackage

// File: rtl/dmux_slot.sv
// One-entry holding register for a single output channel.
// A load on the same edge as a drain keeps the slot FULL with the new word.
module dmux_slot
  import dmux2way16_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] held,
  output logic             ready
);

  logic [0:0]       state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    if (load) begin
      state_next = SLOT_FULL;
      data_next  = data;
    end else if (drain) begin
      state_next = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SLOT_EMPTY;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
    end
  end

  assign valid = (state_reg == SLOT_FULL);
  assign held  = data_reg;
  // Drain only matters when FULL, so an EMPTY slot is always ready.
  assign ready = ~valid | drain;

endmodule

// File: rtl/dmux2way16_stream.sv
// Registered 1-to-2 word demultiplexer with valid/ready on all sides
// and a per-channel count of accepted words.
module dmux2way16_stream
  import dmux2way16_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [1:0]       load;
  logic [1:0]       drain;
  logic [1:0]       slot_valid;
  logic [1:0]       slot_ready;
  logic [WIDTH-1:0] held [2];
  logic [CNT_W-1:0] cnt_reg [2];
  logic             accept;

  assign drain[CH0] = out0_ready;
  assign drain[CH1] = out1_ready;

  // Only the selected slot gates the input, giving head-of-line blocking.
  assign in_ready = rst_n & slot_ready[in_sel];
  assign accept   = in_valid & in_ready;

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    assign load[gi] = accept & (in_sel == 1'(gi));

    dmux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load[gi]),
      .data (in_data),
      .drain(drain[gi]),
      .valid(slot_valid[gi]),
      .held (held[gi]),
      .ready(slot_ready[gi])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg[gi] <= '0;
      end else if (load[gi]) begin
        cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
      end
    end
  end

  assign out0_data  = held[CH0];
  assign out0_valid = slot_valid[CH0];
  assign out1_data  = held[CH1];
  assign out1_valid = slot_valid[CH1];
  assign cnt0       = cnt_reg[CH0];
  assign cnt1       = cnt_reg[CH1];

endmodule

// File: tb/tb_dmux2way16_stream.sv
// Directed self-checking bench for dmux2way16_stream.
// Inputs change on the falling edge; outputs are sampled on or just after it.
module tb_dmux2way16_stream;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [15:0] cnt0;
  logic [15:0] cnt1;

  int checks;
  int failures;

  dmux2way16_stream #(.WIDTH(16), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data (out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    in_data = 16'h1234; in_sel = 1'b0; in_valid = 1'b1; out0_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_pre_in_ready actual=%b expected=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 16'h1234) begin
      failures++; $display("FAIL rst_pre_load actual=%b/%h expected=1/1234", out0_valid, out0_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out0_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid actual=%b expected=0", out0_valid); end
    in_valid = 1'b1; in_sel = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_low actual=%b expected=0", in_ready); end
    @(negedge clk);
    checks++;
    if (out0_data !== 16'h0000 || cnt0 !== 16'h0000 || in_ready !== 1'b0) begin
      failures++; $display("FAIL rst_state actual=%h/%h/%b expected=0000/0000/0", out0_data, cnt0, in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out0_valid !== 1'b0 || cnt0 !== 16'h0000) begin
      failures++; $display("FAIL rst_release actual=%b/%b/%h expected=1/0/0000", in_ready, out0_valid, cnt0);
    end
    in_valid = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_ch1();
    @(negedge clk);
    in_data = 16'hBEEF; in_sel = 1'b1; in_valid = 1'b1; out1_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_data = 16'h5555; in_sel = 1'b0;
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 16'hBEEF || out0_valid !== 1'b0 || cnt1 !== 16'd1) begin
      failures++;
      $display("FAIL single_ch1 actual=%b/%h/%b/%h expected=1/beef/0/0001", out1_valid, out1_data, out0_valid, cnt1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out1_valid !== 1'b1 || out1_data !== 16'hBEEF) begin
        failures++; $display("FAIL single_hold cyc=%0d actual=%b/%h expected=1/beef", i, out1_valid, out1_data);
      end
    end
    out1_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out1_valid !== 1'b0) begin failures++; $display("FAIL single_drain actual=%b expected=0", out1_valid); end
    out1_ready = 1'b0;
    $display("test_single_ch1 done");
  endtask

  task automatic test_backpressure();
    // cnt0 is 0 and cnt1 is 1 entering this test
    @(negedge clk);
    in_data = 16'h00C0; in_sel = 1'b0; in_valid = 1'b1; out0_ready = 1'b0; out1_ready = 1'b0;
    @(negedge clk);
    in_data = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL hol_ready cyc=%0d actual=%b expected=0", i, in_ready); end
      @(negedge clk);
      checks++;
      if (cnt0 !== 16'd1 || out0_data !== 16'h00C0) begin
        failures++; $display("FAIL hol_hold cyc=%0d actual=%h/%h expected=0001/00c0", i, cnt0, out0_data);
      end
    end
    in_sel = 1'b1; in_data = 16'h0002;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL hol_other_ready actual=%b expected=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 16'h0002 || cnt1 !== 16'd2 || out0_data !== 16'h00C0) begin
      failures++;
      $display("FAIL hol_other_accept actual=%b/%h/%h/%h expected=1/0002/0002/00c0", out1_valid, out1_data, cnt1, out0_data);
    end
    out0_ready = 1'b1; out1_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      failures++; $display("FAIL hol_both_drain actual=%b/%b expected=0/0", out0_valid, out1_valid);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_streaming();
    do_reset();
    out0_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_data = 16'(i); in_sel = 1'b0; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready i=%0d actual=%b expected=1", i, in_ready); end
      if (i > 0) begin
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 16'(i - 1)) begin
          failures++; $display("FAIL stream_out i=%0d actual=%b/%h expected=1/%h", i, out0_valid, out0_data, 16'(i - 1));
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 16'h0007) begin
      failures++; $display("FAIL stream_last actual=%b/%h expected=1/0007", out0_valid, out0_data);
    end
    @(negedge clk);
    checks++;
    if (out0_valid !== 1'b0 || cnt0 !== 16'd8) begin
      failures++; $display("FAIL stream_end actual=%b/%h expected=0/0008", out0_valid, cnt0);
    end
    $display("test_streaming done");
  endtask

  task automatic test_alternating();
    logic [15:0] words [4];
    logic        sels  [4];
    words = '{16'hA000, 16'hB000, 16'hA001, 16'hB001};
    sels  = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int j = 0; j <= 4; j++) begin
      @(negedge clk);
      if (j > 0) begin
        checks++;
        if (sels[j-1] == 1'b0) begin
          if (out0_valid !== 1'b1 || out0_data !== words[j-1] || out1_valid !== 1'b0) begin
            failures++; $display("FAIL alt_ch0 j=%0d actual=%b/%h/%b expected=1/%h/0", j, out0_valid, out0_data, out1_valid, words[j-1]);
          end
        end else begin
          if (out1_valid !== 1'b1 || out1_data !== words[j-1] || out0_valid !== 1'b0) begin
            failures++; $display("FAIL alt_ch1 j=%0d actual=%b/%h/%b expected=1/%h/0", j, out1_valid, out1_data, out0_valid, words[j-1]);
          end
        end
      end
      if (j < 4) begin
        in_data = words[j]; in_sel = sels[j]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++;
    if (cnt0 !== 16'd2 || cnt1 !== 16'd2) begin
      failures++; $display("FAIL alt_counts actual=%h/%h expected=0002/0002", cnt0, cnt1);
    end
    $display("test_alternating done");
  endtask

  task automatic test_wrap();
    do_reset();
    out0_ready = 1'b1; out1_ready = 1'b1;
    @(negedge clk);
    in_data = 16'h0C01; in_sel = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_sel = 1'b0; in_data = 16'h0C00;
    repeat (65535) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (cnt0 !== 16'hFFFF || cnt1 !== 16'd1) begin
      failures++; $display("FAIL wrap_pre actual=%h/%h expected=ffff/0001", cnt0, cnt1);
    end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (cnt0 !== 16'h0000 || cnt1 !== 16'd1) begin
      failures++; $display("FAIL wrap_post actual=%h/%h expected=0000/0001", cnt0, cnt1);
    end
    $display("test_wrap done");
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single_ch1();
    test_backpressure();
    test_streaming();
    test_alternating();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmux2way16_stream.md
Name: dmux2way16_stream

Overview:
- Registered 1-to-2 word demultiplexer; the inverse of the 16-bit 2-way mux.
- Routes each input word to output channel 0 or 1, selected per word by sel.
- Uses valid/ready handshakes on the input and on both outputs.
- Holds one word per channel and counts words accepted per channel.
- Sits between the ALU/memory datapath and two independent consumers.

Parameters:
WIDTH, 16, data word width in bits
CNT_W, 16, width of the per-channel accept counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  input word
in_sel  input  1  destination channel, valid with in_valid (0 -> out0, 1 -> out1)
in_valid  input  1  input word and in_sel present
in_ready  output  1  block accepts the input word this cycle
out0_data  output  WIDTH  channel 0 held word
out0_valid  output  1  channel 0 holds a word
out0_ready  input  1  channel 0 consumer takes the word
out1_data  output  WIDTH  channel 1 held word
out1_valid  output  1  channel 1 holds a word
out1_ready  input  1  channel 1 consumer takes the word
cnt0  output  CNT_W  words accepted for channel 0
cnt1  output  CNT_W  words accepted for channel 1

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - out0_valid, out1_valid = 0.
  - out0_data, out1_data = 0.
  - cnt0, cnt1 = 0.
  - in_ready = 0 while rst_n is low; it is gated by rst_n even though it is combinational.
- Slot per channel k: one-entry register with two states, EMPTY and FULL. outk_valid = (state == FULL).
- Input readiness: in_ready = rst_n & (~outk_valid | outk_ready), where k = in_sel.
  - This is a combinational path from outk_ready to in_ready. It is intentional and gives full throughput.
- Accept: in_valid & in_ready on a clock edge.
  - Slot in_sel loads in_data, and its state becomes FULL.
  - Latency is 1 cycle: the word appears on outk_data in the cycle after acceptance.
- Drain: outk_valid & outk_ready on a clock edge moves slot k to EMPTY, unless slot k is reloaded on the same edge.
- Simultaneous drain and reload of one slot: the slot stays FULL with the new word. There is no bubble, so 1 word/cycle is sustained per channel.
- Simultaneous drain of the slot that is not selected: independent; both transitions happen on the same edge.
- Head-of-line blocking: if the slot selected by in_sel is FULL and not draining, in_ready = 0, even when the other slot is EMPTY. Word order is preserved per source; there is no reordering.
- Stability: while outk_valid & ~outk_ready, outk_data is held constant.
- Changes to in_data and in_sel while in_ready = 0 have no effect.
- Counters:
  - cntk increments by 1 on each accept to channel k, and only on accepts (not on drains).
  - Modulo 2^CNT_W: 0xFFFF + 1 -> 0x0000 with no flag.
- Reset mid-operation: held words are discarded, valids drop asynchronously, and counters clear. The first accept after rst_n rises behaves as the first accept after power-up.
- in_valid = 0 leaves all state unchanged, apart from drains.

Decomposition:
- Shared package: WIDTH_DEFAULT = 16, CNT_W_DEFAULT = 16, channel index constants CH0 = 0 and CH1 = 1.
- Sub-module dmux_slot, instantiated twice:
  - Inputs: load, data, drain.
  - Outputs: valid, held data, and a ready term ~valid | drain.
- The top level contains in_sel decoding, in_ready selection, and the two counters.

Test Plan:
- Reset check: reset while slot 0 is FULL with 0x1234, then release -> out0_valid = 0, out0_data = 0x0000, cnt0 = 0; in_ready = 0 during reset and 1 after (in_valid = 1, in_sel = 0).
- Single word to channel 1: push 0xBEEF with in_sel = 1, out1_ready = 0 -> next cycle out1_valid = 1, out1_data = 0xBEEF, out0_valid = 0, cnt1 = 1.
  - Hold 5 cycles -> data stable.
  - Raise out1_ready -> out1_valid = 0 the next cycle.
- Back-pressure and head-of-line: slot 0 FULL with out0_ready = 0, present in_sel = 0 with 0x0001 -> in_ready = 0 for 3 cycles and cnt0 is unchanged.
  - Present in_sel = 1 instead -> in_ready = 1 and accepted.
- Streaming: 8 words 0x0000..0x0007 to channel 0 with out0_ready = 1 every cycle -> in_ready held 1 and out0 emits 0x0000..0x0007 on consecutive cycles, each one cycle after acceptance; cnt0 = 8.
- Alternating sel: send 0xA000 to channel 0, 0xB000 to channel 1, 0xA001 to channel 0, 0xB001 to channel 1 -> each channel receives its words in order and cnt0 = cnt1 = 2.
- Counter wrap: preload via 65535 accepts to channel 0 (or force cnt0 = 0xFFFF), then accept one more -> cnt0 = 0x0000 and cnt1 is unchanged.
